// File: rtl/fixed_lat_pkg.sv
// Shared definitions for the fixed-latency issue controller slice.
//
// Contents:
//   DataWidthDef - default payload width of the delay pipe
//   payload_t    - payload typedef at the default width
//   occ_width()  - bits needed to hold a credit / entry count 0..entries
//   ptr_width()  - bits needed for a FIFO index 0..entries-1 (minimum 1)
package fixed_lat_pkg;

  localparam int unsigned DataWidthDef = 101;

  typedef logic [DataWidthDef-1:0] payload_t;

  function automatic int unsigned occ_width(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

  // A single-entry FIFO still needs a 1-bit pointer to index its storage.
  function automatic int unsigned ptr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/lat_resp_fifo.sv
// Response FIFO behind the fixed-latency pipe.
//
// The pipe cannot stall, so the controller guarantees via credits that a
// push never lands on a full FIFO; that case is only asserted, not handled.
//
// Ports:
//   clk_i       - clock
//   rst_i       - synchronous active-high reset (pointers and count only)
//   flush_i     - synchronous drop of all entries; same-edge push/pop ignored
//   push_i      - write push_data_i at the tail
//   push_data_i - data to write
//   pop_i       - advance the head
//   count_o     - number of stored entries
//   head_o      - data at the head (valid when count_o != 0)
module lat_resp_fifo
  import fixed_lat_pkg::*;
#(
  parameter int unsigned BufDepth  = 4,
  parameter int unsigned DataWidth = DataWidthDef,
  localparam int unsigned PtrW     = ptr_width(BufDepth),
  localparam int unsigned CntW     = occ_width(BufDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [CntW-1:0]      count_o,
  output logic [DataWidth-1:0] head_o
);

  logic [DataWidth-1:0] mem_q [BufDepth];
  logic [PtrW-1:0]      wr_q;
  logic [PtrW-1:0]      rd_q;
  logic [CntW-1:0]      cnt_q;
  logic                 clr;

  assign clr = rst_i | flush_i;

  // Explicit compare-and-zero so non-power-of-2 depths wrap correctly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_i)  rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; validity is carried by the count alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Credits make these unreachable; they flag a broken credit loop.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (clr)
    !(push_i && !pop_i && (cnt_q == CntW'(BufDepth))));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (clr)
    !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/fixed_lat_issue_ctrl.sv
// Issue and credit controller for a fixed-latency, non-stallable delay pipe.
//
// Requests accepted on req_valid_i/req_ready_o are driven onto pipe_data_o.
// A Depth-bit valid shift vector follows each accepted beat through the
// external pipe; when its bit reaches the end, pipe_data_i is captured into
// the response FIFO, which is presented on resp_valid_o/resp_ready_i.
// Issue-to-response latency is Depth+1 cycles. One credit is held per beat
// from accept until pop, so in-flight plus buffered never exceeds BufDepth.
//
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset, priority over flush_i
//   flush_i      - drop all in-flight and buffered entries
//   req_valid_i  - request valid
//   req_ready_o  - request ready (registered-credit based)
//   req_data_i   - request payload
//   pipe_data_o  - payload into the pipe (zero when not issuing)
//   pipe_data_i  - payload out of the pipe
//   resp_valid_o - response valid (FIFO non-empty)
//   resp_ready_i - downstream ready
//   resp_data_o  - FIFO head
//   occupancy_o  - credits in use
module fixed_lat_issue_ctrl
  import fixed_lat_pkg::*;
#(
  parameter int unsigned Depth     = 1,
  parameter int unsigned BufDepth  = 4,
  parameter int unsigned DataWidth = DataWidthDef,
  localparam int unsigned OccW     = occ_width(BufDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] req_data_i,
  output logic [DataWidth-1:0] pipe_data_o,
  input  logic [DataWidth-1:0] pipe_data_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_data_o,
  output logic [OccW-1:0]      occupancy_o
);

  logic [Depth-1:0] vld_q;
  logic [Depth-1:0] vld_d;
  logic [OccW-1:0]  occ_q;
  logic [OccW-1:0]  occ_d;
  logic [OccW-1:0]  fifo_count;
  logic             fire;
  logic             pop;
  logic             capture;

  // Ready depends only on registered credits, never on resp_ready_i.
  assign req_ready_o = (occ_q < OccW'(BufDepth)) && !flush_i && !rst_i;
  assign fire        = req_valid_i && req_ready_o;
  assign pipe_data_o = fire ? req_data_i : '0;

  generate
    if (Depth == 1) begin : g_vld_single
      assign vld_d = fire;
    end else begin : g_vld_shift
      assign vld_d = {vld_q[Depth-2:0], fire};
    end
  endgenerate

  assign capture = vld_q[Depth-1];
  assign pop     = resp_valid_o && resp_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (fire && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!fire && pop) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Clearing vld_q is what makes stale pipe contents harmless after a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  lat_resp_fifo #(
    .BufDepth  (BufDepth),
    .DataWidth (DataWidth)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (capture),
    .push_data_i (pipe_data_i),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (resp_data_o)
  );

  assign resp_valid_o = (fifo_count != '0);
  assign occupancy_o  = occ_q;

  // Every credit is either a set valid bit or a FIFO entry.
  a_credit_balance : assert property (@(posedge clk_i) disable iff (rst_i)
    occ_q == (OccW'($countones(vld_q)) + fifo_count));

endmodule
